// File: rtl/dna_seq_packer_pkg.sv
// dna_pkg: shared types and constants for the DNA sequence packer.
//   dna_base_t     - 2-bit nucleotide code (A=00, C=01, G=10, T=11)
//   BASES_PER_WORD - bases packed into one buffer word
//   DNA_WORD_W     - width of a packed buffer word
//   ASCII_*        - the eight characters that encode to a base
package dna_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } dna_base_t;

  localparam int BASES_PER_WORD = 16;
  localparam int DNA_WORD_W     = 32;

  localparam logic [7:0] ASCII_A_UC = 8'h41;
  localparam logic [7:0] ASCII_C_UC = 8'h43;
  localparam logic [7:0] ASCII_G_UC = 8'h47;
  localparam logic [7:0] ASCII_T_UC = 8'h54;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_G_LC = 8'h67;
  localparam logic [7:0] ASCII_T_LC = 8'h74;

endpackage

// File: rtl/dna_seq_packer_if.sv
// dna_seq_packer_if: character stream in, packed-word write port out.
//   in_valid/in_char/in_last/in_ready - ASCII character handshake
//   fifo_rd                           - consumer read strobe
//   fifo_wr/fifo_wdata/fifo_wlen/fifo_wlast - word write to the buffer
//   fifo_count/fifo_full              - buffer occupancy as tracked by the packer
// Modports: master = upstream producer / consumer side, slave = the packer.
interface dna_seq_packer_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     in_valid;
  logic [7:0]               in_char;
  logic                     in_last;
  logic                     in_ready;
  logic                     fifo_rd;
  logic                     fifo_wr;
  logic [31:0]              fifo_wdata;
  logic [4:0]               fifo_wlen;
  logic                     fifo_wlast;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     fifo_full;

  modport master (
    output in_valid, in_char, in_last, fifo_rd,
    input  in_ready, fifo_wr, fifo_wdata, fifo_wlen, fifo_wlast,
           fifo_count, fifo_full
  );

  modport slave (
    input  in_valid, in_char, in_last, fifo_rd,
    output in_ready, fifo_wr, fifo_wdata, fifo_wlen, fifo_wlast,
           fifo_count, fifo_full
  );
endinterface

// File: rtl/dna_seq_packer_encoder.sv
// dna_base_encoder: combinational ASCII-to-base encoder.
//   in_char - ASCII character
//   code    - 2-bit base code (BASE_A when invalid)
//   valid   - 1 when in_char is one of A/C/G/T in either case
module dna_base_encoder
  import dna_pkg::*;
(
  input  logic [7:0] in_char,
  output dna_base_t  code,
  output logic       valid
);

  always_comb begin
    code  = BASE_A;
    valid = 1'b1;
    case (in_char)
      ASCII_A_UC, ASCII_A_LC: code = BASE_A;
      ASCII_C_UC, ASCII_C_LC: code = BASE_C;
      ASCII_G_UC, ASCII_G_LC: code = BASE_G;
      ASCII_T_UC, ASCII_T_LC: code = BASE_T;
      default:                valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/dna_seq_packer.sv
// dna_seq_packer: encodes an ASCII nucleotide stream to 2-bit codes, packs
// 16 bases LSB-first into 32-bit words, issues one write strobe per word and
// tracks buffer occupancy to apply back-pressure.
// Ports:
//   clk, reset    - clock (rising edge), asynchronous active-high reset
//   bus           - dna_seq_packer_if.slave: character handshake + buffer port
//   err_invalid   - sticky, set when a non-ACGT character was dropped
//   base_count    - saturating count of accepted valid bases
//   invalid_count - saturating count of dropped characters
// Build option: define DNA_PACK_STATS_EN to implement base_count and
// invalid_count; otherwise both are tied to zero.
// FIFO_DEPTH_LOG2 (1..16) must match the pointer controller's ADDR_WIDTH.
module dna_seq_packer
  import dna_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dna_seq_packer_if.slave       bus,
  output logic                  err_invalid,
  output logic [31:0]           base_count,
  output logic [15:0]           invalid_count
);

  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [3:0] LAST_IDX = 4'(BASES_PER_WORD - 1);

  function automatic logic [DNA_WORD_W-1:0] pack_base(
    input logic [DNA_WORD_W-1:0] word,
    input logic [3:0]            idx,
    input dna_base_t             code
  );
    return word | ({30'd0, code} << {idx, 1'b0});
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  dna_base_t             enc_code;
  logic                  enc_valid;
  logic                  accept;
  logic                  word_done;
  logic                  wr;
  logic [DNA_WORD_W-1:0] nxt_data;
  logic [4:0]            nxt_len;

  logic [DNA_WORD_W-1:0] acc_data_p0;
  logic [3:0]            acc_len_p0;

  logic [DNA_WORD_W-1:0] out_data_p1;
  logic [4:0]            out_len_p1;
  logic                  out_last_p1;
  logic                  vld_p1;

  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;
  logic                  full_q;

  dna_base_encoder u_enc (
    .in_char (bus.in_char),
    .code    (enc_code),
    .valid   (enc_valid)
  );

  // The only stall: a finished word is waiting and the buffer has no room.
  assign bus.in_ready = ~reset & ~(vld_p1 & full_q);
  assign accept       = bus.in_valid & bus.in_ready;
  assign wr           = vld_p1 & ~full_q;

  always_comb begin
    nxt_data = acc_data_p0;
    nxt_len  = {1'b0, acc_len_p0};
    if (enc_valid) begin
      nxt_data = pack_base(acc_data_p0, acc_len_p0, enc_code);
      nxt_len  = {1'b0, acc_len_p0} + 5'd1;
    end
    // in_last on an empty accumulator (e.g. a lone invalid char) emits nothing.
    word_done = accept & ((enc_valid & (acc_len_p0 == LAST_IDX)) |
                          (bus.in_last & (nxt_len != 5'd0)));
  end

  // Stage p0: accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_data_p0 <= '0;
      acc_len_p0  <= '0;
    end else if (word_done) begin
      acc_data_p0 <= '0;
      acc_len_p0  <= '0;
    end else if (accept) begin
      acc_data_p0 <= nxt_data;
      acc_len_p0  <= nxt_len[3:0];
    end
  end

  // Stage p1: output register; a new word may load in the same cycle the
  // previous one is written, so completion has priority over clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_p1 <= '0;
      out_len_p1  <= '0;
      out_last_p1 <= 1'b0;
      vld_p1      <= 1'b0;
    end else if (word_done) begin
      out_data_p1 <= nxt_data;
      out_len_p1  <= nxt_len;
      out_last_p1 <= bus.in_last;
      vld_p1      <= 1'b1;
    end else if (wr) begin
      vld_p1      <= 1'b0;
    end
  end

  assign bus.fifo_wr    = wr;
  assign bus.fifo_wdata = out_data_p1;
  assign bus.fifo_wlen  = out_len_p1;
  assign bus.fifo_wlast = out_last_p1;

  always_comb begin
    count_nxt = count_q;
    if (wr & ~bus.fifo_rd)
      count_nxt = count_q + CNT_W'(1);
    else if (bus.fifo_rd & ~wr & (count_q != '0))
      count_nxt = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH);
    end
  end

  assign bus.fifo_count = count_q;
  assign bus.fifo_full  = full_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_invalid <= 1'b0;
    else if (accept & ~enc_valid)
      err_invalid <= 1'b1;
  end

`ifdef DNA_PACK_STATS_EN
  logic [31:0] base_cnt_q;
  logic [15:0] inv_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_cnt_q <= '0;
      inv_cnt_q  <= '0;
    end else if (accept) begin
      if (enc_valid)
        base_cnt_q <= sat_inc32(base_cnt_q);
      else
        inv_cnt_q  <= sat_inc16(inv_cnt_q);
    end
  end

  assign base_count    = base_cnt_q;
  assign invalid_count = inv_cnt_q;
`else
  assign base_count    = 32'd0;
  assign invalid_count = 16'd0;
`endif

endmodule

// File: tb/tb_dna_seq_packer.sv
// tb_dna_seq_packer: directed bench for dna_seq_packer. Two instances: depth
// 16 (main function, latency, occupancy, invalid chars, reset mid-word) and
// depth 4 (back-pressure and full release).
module tb_dna_seq_packer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  logic        err_a, err_b;
  logic [31:0] bc_a, bc_b;
  logic [15:0] ic_a, ic_b;

  dna_seq_packer_if #(.FIFO_DEPTH_LOG2(4)) ia ();
  dna_seq_packer_if #(.FIFO_DEPTH_LOG2(2)) ib ();

  dna_seq_packer #(.FIFO_DEPTH_LOG2(4)) dut_a (
    .clk           (clk),
    .reset         (reset),
    .bus           (ia),
    .err_invalid   (err_a),
    .base_count    (bc_a),
    .invalid_count (ic_a)
  );

  dna_seq_packer #(.FIFO_DEPTH_LOG2(2)) dut_b (
    .clk           (clk),
    .reset         (reset),
    .bus           (ib),
    .err_invalid   (err_b),
    .base_count    (bc_b),
    .invalid_count (ic_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Captured writes: {last, len, data}
  logic [37:0] qa[$];
  logic [37:0] qb[$];

  always @(negedge clk) begin
    if (ia.fifo_wr) qa.push_back({ia.fifo_wlast, ia.fifo_wlen, ia.fifo_wdata});
    if (ib.fifo_wr) qb.push_back({ib.fifo_wlast, ib.fifo_wlen, ib.fifo_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input bit use_b, input logic [7:0] ch, input logic last);
    int waitc;
    logic rdy;
    @(negedge clk);
    if (use_b) begin
      ib.in_valid = 1'b1; ib.in_char = ch; ib.in_last = last;
    end else begin
      ia.in_valid = 1'b1; ia.in_char = ch; ia.in_last = last;
    end
    waitc = 0;
    rdy = use_b ? ib.in_ready : ia.in_ready;
    while (!rdy) begin
      if (waitc == 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: got in_ready 0 after %0d cycles, required 1", waitc);
        break;
      end
      @(negedge clk);
      waitc++;
      rdy = use_b ? ib.in_ready : ia.in_ready;
    end
    @(posedge clk);
  endtask

  task automatic send_str(input bit use_b, input string s, input logic last_on_end);
    logic [7:0] ch;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      send_char(use_b, ch, last_on_end && (i == s.len() - 1));
    end
  endtask

  task automatic idle(input bit use_b);
    @(negedge clk);
    if (use_b) begin
      ib.in_valid = 1'b0; ib.in_last = 1'b0;
    end else begin
      ia.in_valid = 1'b0; ia.in_last = 1'b0;
    end
  endtask

  task automatic pop_word(input bit use_b, input string tag, input logic [31:0] data,
                          input logic [4:0] len, input logic last);
    logic [37:0] w;
    int sz;
    sz = use_b ? qb.size() : qa.size();
    if (sz == 0) begin
      chk({tag, "_present"}, 64'(sz), 64'd1);
    end else begin
      w = use_b ? qb.pop_front() : qa.pop_front();
      chk({tag, "_wdata"}, 64'(w[31:0]), 64'(data));
      chk({tag, "_wlen"}, 64'(w[36:32]), 64'(len));
      chk({tag, "_wlast"}, 64'(w[37]), 64'(last));
    end
  endtask

  logic [31:0] exp_bc;
  logic [15:0] exp_ic;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    ia.in_valid = 1'b0; ia.in_char = 8'h00; ia.in_last = 1'b0; ia.fifo_rd = 1'b0;
    ib.in_valid = 1'b0; ib.in_char = 8'h00; ib.in_last = 1'b0; ib.fifo_rd = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(ia.in_ready), 64'd0);
    chk("rst_fifo_wr", 64'(ia.fifo_wr), 64'd0);
    chk("rst_count", 64'(ia.fifo_count), 64'd0);
    chk("rst_full", 64'(ia.fifo_full), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_bc", 64'(bc_a), 64'd0);
    chk("rst_b_in_ready", 64'(ib.in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 64'(ia.in_ready), 64'd1);

    // Full word "ACGT" x4, gap-free
    send_str(1'b0, "ACGTACGTACGTACGT", 1'b0);
    idle(1'b0);
    chk("full_wr_latency", 64'(ia.fifo_wr), 64'd1);
    chk("full_count_before", 64'(ia.fifo_count), 64'd0);
    @(negedge clk);
    chk("full_wr_single", 64'(ia.fifo_wr), 64'd0);
    chk("full_count", 64'(ia.fifo_count), 64'd1);

    // Partial last word "GT"
    send_str(1'b0, "GT", 1'b1);
    idle(1'b0);
    chk("part_wr_latency", 64'(ia.fifo_wr), 64'd1);
    @(negedge clk);
    chk("part_count", 64'(ia.fifo_count), 64'd2);

    // Simultaneous read and write at count 2
    send_str(1'b0, "a", 1'b1);
    idle(1'b0);
    chk("sim_wr", 64'(ia.fifo_wr), 64'd1);
    ia.fifo_rd = 1'b1;
    @(negedge clk);
    ia.fifo_rd = 1'b0;
    chk("sim_count", 64'(ia.fifo_count), 64'd2);

    // Drain, then read while empty
    ia.fifo_rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ia.fifo_rd = 1'b0;
    chk("drain_count", 64'(ia.fifo_count), 64'd0);
    ia.fifo_rd = 1'b1;
    @(negedge clk);
    ia.fifo_rd = 1'b0;
    chk("empty_rd_count", 64'(ia.fifo_count), 64'd0);
    chk("empty_rd_full", 64'(ia.fifo_full), 64'd0);

    pop_word(1'b0, "w_full", 32'hE4E4E4E4, 5'd16, 1'b0);
    pop_word(1'b0, "w_part", 32'h0000000E, 5'd2, 1'b1);
    pop_word(1'b0, "w_single", 32'h00000000, 5'd1, 1'b1);

    // Invalid character: "ANC" then 14 more valid bases
    send_str(1'b0, "ANC", 1'b0);
    send_str(1'b0, "GTACGTACGTACGT", 1'b0);
    idle(1'b0);
    chk("inv_err", 64'(err_a), 64'd1);
    repeat (2) @(negedge clk);
    pop_word(1'b0, "w_inv", 32'hE4E4E4E4, 5'd16, 1'b0);
`ifdef DNA_PACK_STATS_EN
    exp_ic = 16'd1;
    exp_bc = 32'd35;
`else
    exp_ic = 16'd0;
    exp_bc = 32'd0;
`endif
    chk("inv_count", 64'(ic_a), 64'(exp_ic));
    chk("base_count", 64'(bc_a), 64'(exp_bc));
    chk("inv_err_sticky", 64'(err_a), 64'd1);

    // Reset mid-word after 7 bases
    send_str(1'b0, "GGGGGGG", 1'b0);
    idle(1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(ia.in_ready), 64'd0);
    chk("mid_rst_err", 64'(err_a), 64'd0);
    chk("mid_rst_count", 64'(ia.fifo_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send_str(1'b0, "CCCCCCCCCCCCCCCC", 1'b0);
    idle(1'b0);
    repeat (2) @(negedge clk);
    chk("mid_rst_nwords", 64'(qa.size()), 64'd1);
    pop_word(1'b0, "w_rst", 32'h55555555, 5'd16, 1'b0);
`ifdef DNA_PACK_STATS_EN
    exp_bc = 32'd16;
`else
    exp_bc = 32'd0;
`endif
    chk("rst_base_count", 64'(bc_a), 64'(exp_bc));

    // Back-pressure on the depth-4 instance: 80 'A', no reads
    for (int i = 0; i < 80; i++) send_char(1'b1, 8'h41, 1'b0);
    idle(1'b1);
    chk("bp_in_ready", 64'(ib.in_ready), 64'd0);
    chk("bp_full", 64'(ib.fifo_full), 64'd1);
    chk("bp_count", 64'(ib.fifo_count), 64'd4);
    chk("bp_nwords", 64'(qb.size()), 64'd4);
    chk("bp_no_wr", 64'(ib.fifo_wr), 64'd0);
    ib.fifo_rd = 1'b1;
    @(negedge clk);
    ib.fifo_rd = 1'b0;
    chk("rel_wr", 64'(ib.fifo_wr), 64'd1);
    chk("rel_full", 64'(ib.fifo_full), 64'd0);
    chk("rel_count", 64'(ib.fifo_count), 64'd3);
    chk("rel_in_ready", 64'(ib.in_ready), 64'd1);
    @(negedge clk);
    chk("after_count", 64'(ib.fifo_count), 64'd4);
    chk("after_full", 64'(ib.fifo_full), 64'd1);
    chk("after_wr", 64'(ib.fifo_wr), 64'd0);
    chk("after_in_ready", 64'(ib.in_ready), 64'd1);
    @(negedge clk);
    chk("bp_total_words", 64'(qb.size()), 64'd5);
    for (int i = 0; i < 5; i++) pop_word(1'b1, "w_bp", 32'h00000000, 5'd16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
